// File: rtl/corr_pkg.sv
// Shared correlator types and constants, plus the ADC-word to sample
// conversion used by the feeder.
package corr_pkg;

  localparam int SAMPLE_W  = 9;
  localparam int ADC_W     = 12;
  localparam int ADC_MID   = 2048;
  localparam int FRAME_LEN = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Remove midscale, round half up by adding 4 before the >>>3, then clamp.
  function automatic sample_t adc_to_sample(input logic [ADC_W-1:0] adc);
    logic signed [ADC_W:0] x_s;
    logic signed [ADC_W:0] y_s;
    sample_t               res_s;
    x_s = $signed({1'b0, adc}) - $signed((ADC_W+1)'(ADC_MID));
    y_s = (x_s + $signed((ADC_W+1)'(4))) >>> 3;
    if (y_s > $signed((ADC_W+1)'(255))) begin
      res_s = 9'h0FF;
    end else if (y_s < -$signed((ADC_W+1)'(256))) begin
      res_s = 9'h100;
    end else begin
      res_s = y_s[SAMPLE_W-1:0];
    end
    return res_s;
  endfunction

endpackage

// File: rtl/corr_feed_fifo.sv
// Single-clock FIFO with a registered head word; the head register always
// holds the entry at the read pointer as of the last clock edge.
module corr_feed_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_r;
  logic [W-1:0]  head_r;
  logic [W-1:0]  head_nxt_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = head_r;
  assign level     = count_r;

  // Next head: a write landing on the next read slot bypasses the array.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = head_r;
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = wdata;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array, not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      head_r   <= head_nxt_s;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/corr_sample_feed.sv
// Converts ADC words to signed samples, buffers them, and advances the
// correlator's input sample once per shift tick (zero-stuffing on underflow).
module corr_sample_feed #(
  parameter int DEPTH    = 16,
  parameter int ADC_W    = 12,
  parameter int SAMPLE_W = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADC_W-1:0]        adc_data,
  input  logic                    adc_valid,
  output logic                    adc_ready,
  input  logic                    shift_tick,
  output logic [SAMPLE_W-1:0]     sample_out,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underflow,
  input  logic                    underflow_clr
);
  import corr_pkg::*;

  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic [SAMPLE_W-1:0] conv_s;
  logic [SAMPLE_W-1:0] head_s;
  logic [SAMPLE_W-1:0] sample_out_r;
  logic                underflow_r;

  assign conv_s     = adc_to_sample(adc_data);
  assign adc_ready  = !full_s;
  assign push_s     = adc_valid && adc_ready;
  // An empty FIFO is never popped, so a same-cycle push simply gets stored.
  assign pop_s      = shift_tick && !empty_s;
  assign sample_out = sample_out_r;
  assign underflow  = underflow_r;

  corr_feed_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (conv_s),
    .pop   (pop_s),
    .head  (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Output sample register and sticky underflow flag (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out_r <= {SAMPLE_W{1'b0}};
      underflow_r  <= 1'b0;
    end else begin
      if (shift_tick) begin
        sample_out_r <= empty_s ? {SAMPLE_W{1'b0}} : head_s;
      end
      if (shift_tick && empty_s) begin
        underflow_r <= 1'b1;
      end else if (underflow_clr) begin
        underflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_corr_sample_feed.sv
// Table-driven and scoreboard bench for corr_sample_feed: every cycle the
// outputs are compared against a queue-based reference model.
module tb_corr_sample_feed;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic        shift_tick;
  logic [8:0]  sample_out;
  logic [4:0]  level;
  logic        underflow;
  logic        underflow_clr;

  int checks = 0;
  int errors = 0;

  int sb[$];
  int mdl_out = 0;
  int mdl_uf  = 0;

  typedef struct {
    logic [11:0] adc;
    int          exp;
  } vec_t;
  vec_t tbl[12];

  corr_sample_feed dut (
    .clk           (clk),
    .reset         (reset),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .adc_ready     (adc_ready),
    .shift_tick    (shift_tick),
    .sample_out    (sample_out),
    .level         (level),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 clk = ~clk;

  function automatic int conv(input int adc);
    int v;
    int y;
    v = adc - 2048 + 4;
    if (v >= 0) y = v / 8;
    else        y = -((-v + 7) / 8);
    if (y > 255)  y = 255;
    if (y < -256) y = -256;
    return y;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, compare all outputs 1 time unit after the edge.
  task automatic step(input logic v, input int d, input logic t, input logic c, input logic r);
    logic acc;
    logic was_empty;
    adc_valid     = v;
    adc_data      = 12'(d);
    shift_tick    = t;
    underflow_clr = c;
    reset         = r;
    acc       = v && (sb.size() != 16);
    was_empty = (sb.size() == 0);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      mdl_out = 0;
      mdl_uf  = 0;
    end else begin
      if (t) begin
        if (was_empty) begin
          mdl_out = 0;
          mdl_uf  = 1;
        end else begin
          mdl_out = sb.pop_front();
        end
      end
      if (acc) sb.push_back(conv(d));
      if (c && !(t && was_empty)) mdl_uf = 0;
    end
    chk("sample_out", $signed(sample_out), mdl_out);
    chk("level", int'(level), sb.size());
    chk("underflow", int'(underflow), mdl_uf);
    chk("adc_ready", int'(adc_ready), (sb.size() != 16) ? 1 : 0);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{12'd2048, 0};
    tbl[1]  = '{12'd2052, 1};
    tbl[2]  = '{12'd4095, 255};
    tbl[3]  = '{12'd0,    -256};
    tbl[4]  = '{12'd2051, 0};
    tbl[5]  = '{12'd2043, -1};
    tbl[6]  = '{12'd2060, 2};
    tbl[7]  = '{12'd4091, 255};
    tbl[8]  = '{12'd4092, 255};
    tbl[9]  = '{12'd1,    -256};
    tbl[10] = '{12'd8,    -255};
    tbl[11] = '{12'd2059, 1};

    // reset then idle
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("rst_sample", $signed(sample_out), 0);
    chk("rst_ready", int'(adc_ready), 1);
    // tick on empty sets underflow, output stays 0
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("empty_tick_uf", int'(underflow), 1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("uf_clear", int'(underflow), 0);

    // conversion table: push all, then drain with ticks
    for (int i = 0; i < 12; i++) step(1'b1, int'(tbl[i].adc), 1'b0, 1'b0, 1'b0);
    chk("tbl_level", int'(level), 12);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("tbl_conv", $signed(sample_out), tbl[i].exp);
    end
    chk("tbl_drained", int'(level), 0);

    // 17 words with valid held: fill, stall, tick frees one slot
    for (int i = 0; i < 17; i++) step(1'b1, 100 + i * 230, 1'b0, 1'b0, 1'b0);
    chk("full_level", int'(level), 16);
    chk("full_ready", int'(adc_ready), 0);
    step(1'b1, 100 + 16 * 230, 1'b1, 1'b0, 1'b0);
    chk("full_tick_level", int'(level), 15);
    step(1'b1, 100 + 16 * 230, 1'b0, 1'b0, 1'b0);
    chk("17th_accepted", int'(level), 16);
    for (int i = 0; i < 16; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("wrap_last", $signed(sample_out), conv(100 + 16 * 230));

    // push + tick with level 3
    for (int i = 0; i < 3; i++) step(1'b1, 2100 + i * 64, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3000, 1'b1, 1'b0, 1'b0);
    chk("pp_level3", int'(level), 3);
    chk("pp_head", $signed(sample_out), conv(2100));
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // push + tick on empty: zero-stuff, stored, next tick outputs it
    step(1'b1, 3500, 1'b1, 1'b0, 1'b0);
    chk("pe_sample", $signed(sample_out), 0);
    chk("pe_uf", int'(underflow), 1);
    chk("pe_level", int'(level), 1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("pe_next", $signed(sample_out), conv(3500));

    // clear and empty tick together: set wins
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("clr_vs_set", int'(underflow), 1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("clr_pulse", int'(underflow), 0);

    // reset with level 5 and nonzero output
    for (int i = 0; i < 6; i++) step(1'b1, 3900 - i * 10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 5);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_sample", $signed(sample_out), 0);
    idle();
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_empty", int'(underflow), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_sample_feed.md
# corr_sample_feed

Upstream feeder for the three-block correlator chain. Accepts 12-bit unsigned ADC words over a valid/ready handshake and converts each to a 9-bit signed, midscale-removed, rounded, saturated sample. Buffers samples in a 16-deep FIFO and presents exactly one new sample on `sample_out` per correlator shift period, so the correlator's `shift_in` stays stable across the whole 64-cycle coefficient sweep.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries, power of two.
- `ADC_W`, 12: ADC word width.
- `SAMPLE_W`, 9: output sample width, two's complement.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `adc_data`  in  ADC_W  unsigned ADC word.
- `adc_valid`  in  1  `adc_data` is valid.
- `adc_ready`  out  1  FIFO can accept a word.
- `shift_tick`  in  1  one-cycle pulse, once per 64-cycle correlator frame; advance the output sample.
- `sample_out`  out  SAMPLE_W  drives correlator `shift_in`.
- `level`  out  5  current FIFO occupancy, 0..16.
- `underflow`  out  1  sticky: a tick found the FIFO empty.
- `underflow_clr`  in  1  clears `underflow`.

## Operation
- Conversion is applied on push; the FIFO stores converted 9-bit values.
  - Compute x = adc_data − 2048 as 13-bit signed.
  - Round: y = (x + 4) >>> 3, arithmetic shift.
  - Saturate y to [−256, 255].
  - Example: 4095 → +255 (saturated); 0 → −256; 2048 → 0; 2052 → +1 (round half up); 2051 → 0.
- Push occurs when `adc_valid && adc_ready`.
- `adc_ready` = (level != DEPTH), combinational from the registered count. A word offered while full is not accepted, and the source holds it.
- Pop occurs on `shift_tick`:
  - FIFO non-empty: `sample_out` ← head, entry removed.
  - FIFO empty: `sample_out` ← 0 (zero-stuff) and `underflow` ← 1.
- Push and pop in the same cycle:
  - Non-empty FIFO: both happen, `level` unchanged.
  - Empty FIFO: no fall-through. The pop zero-stuffs and sets `underflow`, the push is stored, and `level` becomes 1.
  - Full FIFO: `adc_ready` is already low, so only the pop happens.
- `underflow_clr` and a setting event in the same cycle: the set wins.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `level` is a separate counter.

## Timing
- Reset values: `sample_out` = 0, `level` = 0, `underflow` = 0, `adc_ready` = 1, pointers = 0.
- Reset mid-operation discards FIFO contents. Stored data need not be cleared.
- Push latency: a word accepted at edge N is counted in `level` after N and is poppable by a tick at N+1.
- Pop latency: `sample_out` updates on the edge where `shift_tick` = 1 and holds until the next tick.
- `shift_tick` is aligned by the frame sequencer to occur at least one cycle before the correlator's shift enable (coeff step 2). The value is therefore stable when the correlator samples it.
- Ticks are not required to be periodic. Back-to-back ticks pop on every cycle.
- No combinational path from inputs to `sample_out`.

## Structure
- Shared package `corr_pkg` holds:
  - `SAMPLE_W` = 9, `ADC_W` = 12, `ADC_MID` = 2048, `FRAME_LEN` = 64.
  - A `sample_t` typedef, signed [8:0].
  - The conversion as a function `adc_to_sample`.
- One sub-module: `corr_feed_fifo`, a synchronous single-clock FIFO with push/pop/level/full/empty. Read data comes from a registered head. Conversion and the tick/underflow logic stay in the top.

## Test plan
- Reset then idle: `sample_out` = 0, `level` = 0, `adc_ready` = 1, `underflow` = 0. A tick with an empty FIFO sets `underflow` and `sample_out` stays 0.
- Push 2048, 2052, 4095, 0, then tick four times: `sample_out` = 0, 1, 255, −256 in order; `level` 4 → 0.
- Push 17 words with `adc_valid` held high and no ticks: 16 accepted, `adc_ready` low with `level` = 16. A tick accepts the 17th in the following cycle, and output order is preserved across pointer wrap.
- Push and tick in the same cycle with `level` = 3: `level` stays 3 and the correct head is output.
- Push and tick in the same cycle on an empty FIFO: `sample_out` = 0, `underflow` = 1, `level` = 1. The next tick outputs the pushed sample.
- `underflow_clr` pulse clears the flag. Clear plus empty-tick in the same cycle leaves `underflow` = 1. Asserting `reset` with `level` = 5 gives `level` = 0 and `sample_out` = 0 on the next cycle.
